// File: rtl/tile_config_loader.sv
// tile_config_loader: assembles a streamed configuration image in a shadow
// register and commits it atomically to a tile's parallel config bus. The
// tile is held in reset until a committed image is valid.
//
// Optional feature macro: TILE_CONFIG_LOADER_CRC_EN
//   When defined, a CRC-8 word (poly 0x07, init 0, MSB-first) follows the
//   data words and the image is committed only if it matches. This requires
//   WORD_WIDTH >= 8.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | waiting for start, no image committed yet
// S_LOAD  | accepting stream words into the shadow register
// S_CHECK | comparing received CRC with accumulated CRC
// S_DONE  | committed image valid, tile released from reset
// S_ERROR | CRC mismatch, previous image kept, tile in reset
module tile_config_loader #(
  parameter int CONFIG_WIDTH = 194,
  parameter int WORD_WIDTH   = 8,
  localparam int NWORDS      = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
  localparam int CNT_W       = $clog2(NWORDS + 2)
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    tile_nreset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic [CONFIG_WIDTH-1:0] shadow_next;
  logic                    xfer;
  logic                    data_xfer;
  logic                    last_data;

  assign xfer      = word_valid && word_ready;
  assign data_xfer = xfer && (cnt < CNT_W'(NWORDS));
  assign last_data = xfer && (cnt == CNT_W'(NWORDS - 1));

`ifdef TILE_CONFIG_LOADER_CRC_EN
  logic [7:0] crc;
  logic [7:0] crc_rx;

  // One word through the CRC-8 shift register, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] c_in,
                                           input logic [WORD_WIDTH-1:0] w);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      fb = c[7] ^ w[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`else
  assign error = 1'b0;
`endif

  // Drop the current word into its slot; bits past CONFIG_WIDTH-1 fall away.
  always_comb begin
    shadow_next = shadow;
    for (int b = 0; b < CONFIG_WIDTH; b++) begin
      if (data_xfer && (cnt == CNT_W'(b / WORD_WIDTH))) begin
        shadow_next[b] = word_in[b % WORD_WIDTH];
      end
    end
  end

  // Sequencer with registered handshake, status and tile reset outputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shadow      <= '0;
      config_out  <= '0;
      word_ready  <= 1'b0;
      tile_nreset <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef TILE_CONFIG_LOADER_CRC_EN
      error       <= 1'b0;
      crc         <= '0;
      crc_rx      <= '0;
`endif
    end else begin
      shadow <= shadow_next;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state       <= S_LOAD;
            cnt         <= '0;
            word_ready  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            tile_nreset <= 1'b0;
`ifdef TILE_CONFIG_LOADER_CRC_EN
            error       <= 1'b0;
            crc         <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (xfer) begin
            cnt <= cnt + CNT_W'(1);
`ifdef TILE_CONFIG_LOADER_CRC_EN
            // The word after the last data word carries the CRC.
            if (data_xfer) begin
              crc <= crc8_step(crc, word_in);
            end else begin
              crc_rx     <= word_in[7:0];
              word_ready <= 1'b0;
              state      <= S_CHECK;
            end
`else
            if (last_data) begin
              word_ready  <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              tile_nreset <= 1'b1;
              config_out  <= shadow_next;
              state       <= S_DONE;
            end
`endif
          end
        end
`ifdef TILE_CONFIG_LOADER_CRC_EN
        S_CHECK: begin
          busy <= 1'b0;
          if (crc_rx == crc) begin
            done        <= 1'b1;
            tile_nreset <= 1'b1;
            config_out  <= shadow;
            state       <= S_DONE;
          end else begin
            error <= 1'b1;
            state <= S_ERROR;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_config_loader.sv
// Directed bench for tile_config_loader at default parameters.
// Optional feature macro: TILE_CONFIG_LOADER_CRC_EN (bench adapts to it).
module tb_tile_config_loader;

  localparam int CW = 194;
  localparam int WW = 8;
  localparam int NW = 25;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic [CW-1:0] config_out;
  logic          tile_nreset;
  logic          busy;
  logic          done;
  logic          error;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]    cur [NW];
  logic [CW-1:0] img_a;
  logic [CW-1:0] img_b;

  tile_config_loader dut (
    .clock       (clock),
    .nreset      (nreset),
    .start       (start),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .config_out  (config_out),
    .tile_nreset (tile_nreset),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pattern A: 0x00..0x18. Pattern B: k*7+3 (last word 0xAB keeps 2'b11).
  task automatic set_pattern(input int which);
    for (int k = 0; k < NW; k++) cur[k] = (which == 0) ? 8'(k) : 8'(k * 7 + 3);
  endtask

  function automatic logic [CW-1:0] model_img();
    logic [NW*WW-1:0] full;
    full = '0;
    for (int k = 0; k < NW; k++) full[k*WW +: WW] = cur[k];
    return full[CW-1:0];
  endfunction

`ifdef TILE_CONFIG_LOADER_CRC_EN
  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < NW; k++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ cur[k][i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction
`endif

  task automatic do_start(input string tag);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, "_ready"}, 256'(word_ready), 256'd1);
    check({tag, "_busy"}, 256'(busy), 256'd1);
    check({tag, "_tile_nreset"}, 256'(tile_nreset), 256'd0);
  endtask

  // Back-to-back load of cur[]; returns after the completion edge (+1 with CRC).
  task automatic load_b2b(input string tag, input logic [7:0] crc_flip);
    do_start(tag);
    for (int k = 0; k < NW; k++) begin
      word_in = cur[k];
      word_valid = 1'b1;
      if (k == NW - 1) check({tag, "_done_before_last"}, 256'(done), 256'd0);
      @(posedge clock); #1;
    end
`ifdef TILE_CONFIG_LOADER_CRC_EN
    word_in = model_crc() ^ crc_flip;
    @(posedge clock); #1;
    word_valid = 1'b0;
    check({tag, "_check_done"}, 256'(done), 256'd0);
    check({tag, "_check_ready"}, 256'(word_ready), 256'd0);
    @(posedge clock); #1;
`else
    check({tag, "_crcflip_unused"}, 256'(crc_flip), 256'd0);
`endif
    word_valid = 1'b0;
    word_in = 8'h5A;
  endtask

  initial begin
    int ntx;
    logic [CW-1:0] hold;

    // Reset and idle.
    #3 nreset = 1'b0;
    #20 nreset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("rst_config", 256'(config_out), 256'd0);
    check("rst_tile_nreset", 256'(tile_nreset), 256'd0);
    check("rst_ready", 256'(word_ready), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_error", 256'(error), 256'd0);

    // Pattern A back-to-back.
    set_pattern(0);
    img_a = model_img();
    load_b2b("a", 8'h00);
    check("a_done", 256'(done), 256'd1);
    check("a_tile_nreset", 256'(tile_nreset), 256'd1);
    check("a_ready_low", 256'(word_ready), 256'd0);
    check("a_busy_low", 256'(busy), 256'd0);
    check("a_byte0", 256'(config_out[7:0]), 256'h00);
    check("a_byte1", 256'(config_out[15:8]), 256'h01);
    check("a_top", 256'(config_out[193:192]), 256'd0);
    check("a_image", 256'(config_out), 256'(img_a));

    // Pattern B back-to-back; last word 0xAB only contributes 2'b11.
    set_pattern(1);
    img_b = model_img();
    load_b2b("b", 8'h00);
    check("b_done", 256'(done), 256'd1);
    check("b_byte0", 256'(config_out[7:0]), 256'h03);
    check("b_byte1", 256'(config_out[15:8]), 256'h0A);
    check("b_top", 256'(config_out[193:192]), 256'd3);
    check("b_image", 256'(config_out), 256'(img_b));

    // word_in ignored while word_ready is low.
    word_valid = 1'b1;
    word_in = 8'hEE;
    repeat (3) @(posedge clock);
    #1;
    word_valid = 1'b0;
    check("ignored_image", 256'(config_out), 256'(img_b));
    check("ignored_done", 256'(done), 256'd1);

    // Gapped pattern A with a mid-load start pulse.
    set_pattern(0);
`ifdef TILE_CONFIG_LOADER_CRC_EN
    ntx = NW + 1;
`else
    ntx = NW;
`endif
    do_start("gap");
    for (int c = 0; c < 2 * ntx - 1; c++) begin
      word_valid = (c % 2 == 0);
      if (c % 2 == 0) begin
`ifdef TILE_CONFIG_LOADER_CRC_EN
        word_in = (c / 2 < NW) ? cur[c / 2] : model_crc();
`else
        word_in = cur[c / 2];
`endif
      end else begin
        word_in = 8'hC3;
      end
      start = (c == 10);
      if (c == 2 * ntx - 2) check("gap_done_early", 256'(done), 256'd0);
      @(posedge clock); #1;
      if (c == 11) check("gap_busy_after_start", 256'(busy), 256'd1);
    end
    word_valid = 1'b0;
    start = 1'b0;
`ifdef TILE_CONFIG_LOADER_CRC_EN
    @(posedge clock); #1;
`endif
    check("gap_done_49", 256'(done), 256'd1);
    check("gap_image", 256'(config_out), 256'(img_a));

`ifdef TILE_CONFIG_LOADER_CRC_EN
    // Bad CRC after good image A: keep A, hold tile in reset.
    set_pattern(1);
    load_b2b("crcbad", 8'h01);
    check("crcbad_error", 256'(error), 256'd1);
    check("crcbad_done", 256'(done), 256'd0);
    check("crcbad_image", 256'(config_out), 256'(img_a));
    check("crcbad_tile_nreset", 256'(tile_nreset), 256'd0);
    do_start("crcrestart");
    check("crcrestart_error", 256'(error), 256'd0);
    // Let it idle in LOAD, then reset clears it below.
`endif

    // Async reset after word 12 of pattern B.
    hold = config_out;
    check("pre_reset_image_nonzero", 256'(hold == '0), 256'd0);
    nreset = 1'b0;
    #2 nreset = 1'b1;
    @(posedge clock); #1;
    set_pattern(1);
    do_start("mid");
    for (int k = 0; k <= 12; k++) begin
      word_in = cur[k];
      word_valid = 1'b1;
      @(posedge clock); #1;
    end
    word_valid = 1'b0;
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_config", 256'(config_out), 256'd0);
    check("mid_rst_ready", 256'(word_ready), 256'd0);
    check("mid_rst_busy", 256'(busy), 256'd0);
    check("mid_rst_tile_nreset", 256'(tile_nreset), 256'd0);
    #2 nreset = 1'b1;
    @(posedge clock); #1;
    load_b2b("fresh", 8'h00);
    check("fresh_done", 256'(done), 256'd1);
    check("fresh_tile_nreset", 256'(tile_nreset), 256'd1);
    check("fresh_image", 256'(config_out), 256'(img_b));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
